// File: rtl/rope_multi_move.sv
// rope_multi_move: NUM_ROPES independent rope trajectory generators for the player weapon path.
// Define ROPE_HOLD_EN to build the HOLD state that parks a rope at the top line before retracting.
module rope_multi_move #(
  parameter int NUM_ROPES   = 2,
  parameter int Y_SPEED     = 150,
  parameter int TOP_LIMIT   = 26,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_ROPES-1:0]    deploy,
  input  logic [NUM_ROPES-1:0]    hit,
  output logic [NUM_ROPES*11-1:0] topY,
  output logic [NUM_ROPES-1:0]    movingUp,
  output logic [NUM_ROPES-1:0]    retracted
);

  // Positions are 1/64 px fixed point; the rope foot sits on line 479.
  localparam logic signed [16:0] BOTTOM  = 17'sd30656;
  localparam logic signed [17:0] TOP_POS = 18'(TOP_LIMIT * 64);
  localparam logic signed [17:0] Y_STEP  = 18'(Y_SPEED);
`ifdef ROPE_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
`endif

  if (NUM_ROPES < 1 || NUM_ROPES > 4 || Y_SPEED < 1 || TOP_LIMIT < 0 ||
      TOP_LIMIT > 479 || HOLD_FRAMES < 0) begin : gBadParams
    $error("rope_multi_move: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1
`ifdef ROPE_HOLD_EN
    , HOLD = 2'd2
`endif
  } ropeState_t;

  genvar gi;
  for (gi = 0; gi < NUM_ROPES; gi++) begin : gRope
    ropeState_t         stateReg;
    logic signed [16:0] posReg;
    logic               latchReg;
    logic               retractedReg;
    logic signed [17:0] risePos;
    logic               reachesTop;
`ifdef ROPE_HOLD_EN
    logic [HOLD_W-1:0]  holdCntReg;
`endif

    // One extra sign bit so a large step can never wrap past the top line.
    assign risePos    = {posReg[16], posReg} - Y_STEP;
    assign reachesTop = !(risePos > TOP_POS);

    always_ff @(posedge clk) begin
      if (resetN) begin
        stateReg     <= IDLE;
        posReg       <= BOTTOM;
        latchReg     <= 1'b0;
        retractedReg <= 1'b0;
`ifdef ROPE_HOLD_EN
        holdCntReg   <= '0;
`endif
      end else begin
        retractedReg <= 1'b0;
        case (stateReg)
          IDLE: begin
            posReg <= BOTTOM;
            // Hit outranks both a pending launch and a new request.
            if (hit[gi]) begin
              latchReg <= 1'b0;
            end else if (startOfFrame && (latchReg || deploy[gi])) begin
              stateReg <= RISE;
              latchReg <= 1'b0;
            end else if (deploy[gi]) begin
              latchReg <= 1'b1;
            end
          end

          RISE: begin
            latchReg <= 1'b0;
            if (hit[gi]) begin
              stateReg     <= IDLE;
              posReg       <= BOTTOM;
              retractedReg <= 1'b1;
            end else if (startOfFrame) begin
              if (!reachesTop) begin
                posReg <= risePos[16:0];
              end else begin
`ifdef ROPE_HOLD_EN
                stateReg   <= HOLD;
                posReg     <= TOP_POS[16:0];
                holdCntReg <= HOLD_W'(HOLD_FRAMES);
`else
                stateReg     <= IDLE;
                posReg       <= BOTTOM;
                retractedReg <= 1'b1;
`endif
              end
            end
          end

`ifdef ROPE_HOLD_EN
          HOLD: begin
            latchReg <= 1'b0;
            if (hit[gi] || (startOfFrame && holdCntReg == '0)) begin
              stateReg     <= IDLE;
              posReg       <= BOTTOM;
              retractedReg <= 1'b1;
            end else if (startOfFrame) begin
              holdCntReg <= holdCntReg - 1'b1;
            end
          end
`endif

          default: begin
            stateReg <= IDLE;
            posReg   <= BOTTOM;
            latchReg <= 1'b0;
          end
        endcase
      end
    end

    assign topY[gi*11 +: 11] = posReg[16:6];
    assign movingUp[gi]      = (stateReg != IDLE);
    assign retracted[gi]     = retractedReg;
  end

endmodule

// File: tb/tb_rope_multi_move.sv
// Directed plus random bench for rope_multi_move, checked against a frame-count reference model.
// Works for builds with and without ROPE_HOLD_EN.
module tb_rope_multi_move;

  localparam int NR     = 2;
  localparam int YS     = 150;
  localparam int TOPL   = 26;
  localparam int HOLDF  = 30;
  localparam int BOTTOM = 30656;
  localparam int TOPPOS = TOPL * 64;
  localparam logic [NR-1:0] NONE  = '0;
  localparam logic [NR-1:0] ROPE0 = NR'(1);
  localparam logic [NR-1:0] ROPE1 = NR'(2);
  localparam logic [NR-1:0] BOTH  = NR'(3);

  logic             clk = 1'b0;
  logic             resetN;
  logic             startOfFrame;
  logic [NR-1:0]    deploy;
  logic [NR-1:0]    hit;
  logic [NR*11-1:0] topY;
  logic [NR-1:0]    movingUp;
  logic [NR-1:0]    retracted;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a rope is described by how many frames it has been up.
  bit active  [NR];
  bit latch   [NR];
  int nFrames [NR];
  bit expRetr [NR];
  int clampFrame;
  int lifeFrames;

  rope_multi_move #(
    .NUM_ROPES  (NR),
    .Y_SPEED    (YS),
    .TOP_LIMIT  (TOPL),
    .HOLD_FRAMES(HOLDF)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .deploy      (deploy),
    .hit         (hit),
    .topY        (topY),
    .movingUp    (movingUp),
    .retracted   (retracted)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] getTop(input int r);
    return topY[r*11 +: 11];
  endfunction

  function automatic int expPos(input int r);
    if (!active[r]) return BOTTOM;
    if (nFrames[r] < clampFrame) return BOTTOM - nFrames[r] * YS;
    return TOPPOS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate(input logic sof, input logic [NR-1:0] dep,
                             input logic [NR-1:0] h, input logic rst);
    for (int r = 0; r < NR; r++) begin
      expRetr[r] = 1'b0;
      if (rst) begin
        active[r] = 1'b0; latch[r] = 1'b0; nFrames[r] = 0;
      end else if (active[r]) begin
        latch[r] = 1'b0;
        if (h[r]) begin
          active[r] = 1'b0; expRetr[r] = 1'b1;
        end else if (sof) begin
          nFrames[r]++;
          if (nFrames[r] >= lifeFrames) begin
            active[r] = 1'b0; expRetr[r] = 1'b1;
          end
        end
      end else begin
        if (h[r]) latch[r] = 1'b0;
        else if (sof && (latch[r] || dep[r])) begin
          active[r] = 1'b1; nFrames[r] = 0; latch[r] = 1'b0;
        end else if (dep[r]) latch[r] = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    for (int r = 0; r < NR; r++) begin
      check($sformatf("topY%0d", r), 32'(getTop(r)), 32'(expPos(r) >> 6));
      check($sformatf("movingUp%0d", r), 32'(movingUp[r]), 32'(active[r]));
      check($sformatf("retracted%0d", r), 32'(retracted[r]), 32'(expRetr[r]));
    end
  endtask

  task automatic step(input logic sof, input logic [NR-1:0] dep,
                      input logic [NR-1:0] h, input logic rst);
    startOfFrame = sof; deploy = dep; hit = h; resetN = rst;
    @(posedge clk);
    modelUpdate(sof, dep, h, rst);
    #1;
    compareAll();
    startOfFrame = 1'b0; deploy = NONE; hit = NONE; resetN = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, NONE, NONE, 1'b0);
  endtask

  initial begin
    int retFrame;
    resetN = 1'b1; startOfFrame = 1'b0; deploy = NONE; hit = NONE;
    clampFrame = 1;
    while (BOTTOM - clampFrame * YS > TOPPOS) clampFrame++;
`ifdef ROPE_HOLD_EN
    lifeFrames = clampFrame + HOLDF + 1;
`else
    lifeFrames = clampFrame;
`endif
    for (int r = 0; r < NR; r++) begin
      active[r] = 1'b0; latch[r] = 1'b0; nFrames[r] = 0; expRetr[r] = 1'b0;
    end

    // Reset state and quiet idling
    repeat (3) step(1'b0, NONE, NONE, 1'b1);
    check("reset_top0", 32'(getTop(0)), 32'd479);
    check("reset_top1", 32'(getTop(1)), 32'd479);
    check("reset_moving", 32'(movingUp), 32'd0);
    for (int i = 0; i < 8; i++) step(i % 3 == 0, NONE, NONE, 1'b0);

    // Full flight of rope 0
    step(1'b0, ROPE0, NONE, 1'b0);
    idle(1);
    step(1'b1, NONE, NONE, 1'b0);
    check("launch_moving0", 32'(movingUp[0]), 32'd1);
    check("launch_top0", 32'(getTop(0)), 32'd479);
    idle(2);
    for (int f = 1; f <= 193; f++) begin
      step(1'b1, NONE, NONE, 1'b0);
      if (f == 1) check("frame1_top0", 32'(getTop(0)), 32'd476);
      idle(1);
    end
    check("frame193_top0", 32'(getTop(0)), 32'd26);
    step(1'b1, NONE, NONE, 1'b0);
`ifdef ROPE_HOLD_EN
    check("frame194_top0", 32'(getTop(0)), 32'd26);
    check("frame194_moving0", 32'(movingUp[0]), 32'd1);
    retFrame = -1;
    for (int f = 195; f <= 260 && retFrame < 0; f++) begin
      step(1'b1, NONE, NONE, 1'b0);
      if (retracted[0]) retFrame = f;
      idle(1);
    end
    check("hold_retract_frame", 32'(retFrame), 32'd225);
`else
    check("frame194_top0", 32'(getTop(0)), 32'd479);
    check("frame194_retracted0", 32'(retracted[0]), 32'd1);
    check("frame194_moving0", 32'(movingUp[0]), 32'd0);
`endif
    idle(3);

    // Hit on rope 1 coinciding with a frame pulse; rope 0 keeps rising
    step(1'b0, BOTH, NONE, 1'b0);
    step(1'b1, NONE, NONE, 1'b0);
    for (int f = 1; f <= 50; f++) begin
      step(1'b1, NONE, NONE, 1'b0);
      idle(1);
    end
    check("frame50_top1", 32'(getTop(1)), 32'd361);
    step(1'b1, NONE, ROPE1, 1'b0);
    check("hit_top1", 32'(getTop(1)), 32'd479);
    check("hit_moving1", 32'(movingUp[1]), 32'd0);
    check("hit_retracted1", 32'(retracted[1]), 32'd1);
    check("hit_moving0", 32'(movingUp[0]), 32'd1);
    check("hit_top0", 32'(getTop(0)), 32'd359);
    step(1'b0, NONE, ROPE0, 1'b0);
    idle(2);

    // Deploy while rising, and deploy together with hit in IDLE, must not launch
    step(1'b0, ROPE0, NONE, 1'b0);
    step(1'b1, NONE, NONE, 1'b0);
    for (int f = 0; f < 5; f++) step(1'b1, NONE, NONE, 1'b0);
    step(1'b0, ROPE0, NONE, 1'b0);
    step(1'b0, NONE, ROPE0, 1'b0);
    step(1'b1, NONE, NONE, 1'b0);
    check("rise_deploy_ignored", 32'(movingUp[0]), 32'd0);
    step(1'b0, ROPE0, ROPE0, 1'b0);
    step(1'b1, NONE, NONE, 1'b0);
    check("deploy_hit_no_launch", 32'(movingUp[0]), 32'd0);
    idle(2);

    // Reset in mid-flight
    step(1'b0, ROPE0, NONE, 1'b0);
    step(1'b1, NONE, NONE, 1'b0);
    for (int f = 0; f < 100; f++) step(1'b1, NONE, NONE, 1'b0);
    step(1'b0, NONE, NONE, 1'b1);
    check("midreset_top0", 32'(getTop(0)), 32'd479);
    check("midreset_moving", 32'(movingUp), 32'd0);
    check("midreset_retracted", 32'(retracted), 32'd0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [NR-1:0] d, h;
      for (int r = 0; r < NR; r++) begin
        d[r] = ($urandom_range(0, 5) == 0);
        h[r] = ($urandom_range(0, 63) == 0);
      end
      step($urandom_range(0, 2) == 0, d, h, $urandom_range(0, 799) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rope_multi_move.md
# rope_multi_move

Parametrised multi-channel rope trajectory generator for the player weapon path. It is the next generation of the single-rope mover and drives `NUM_ROPES` independent ropes, each with its own per-rope state machine. Each rope rises at a fixed sub-pixel speed once per frame and clamps at a configurable top line. A rope can retract early on a collision hit. Outputs feed the rope drawing and collision blocks.

## Interface
- `NUM_ROPES`, default 2: number of independent ropes, 1..4.
- `Y_SPEED`, default 150: rise per frame in 1/64 px. Positive value.
- `TOP_LIMIT`, default 26: top Y clamp in pixels.
- `HOLD_FRAMES`, default 30: frames a rope stays at the top before retracting. Only used with `ROPE_HOLD_EN`.
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset. Synchronous and active-high: asserted = 1, sampled on the `clk` rising edge. The name is kept for codebase consistency only.
- `startOfFrame`, in, 1: one-cycle pulse at the start of each frame.
- `deploy`, in, `NUM_ROPES`: per-rope fire request. Any width of pulse is accepted.
- `hit`, in, `NUM_ROPES`: per-rope collision. Forces an immediate retract.
- `topY`, out, `NUM_ROPES*11`: rope i top Y in pixels, at bits [11i+10:11i].
- `movingUp`, out, `NUM_ROPES`: rope i is active, in state RISE or HOLD.
- `retracted`, out, `NUM_ROPES`: one-cycle pulse when rope i returns to IDLE.

## Operation
- Position register per rope: 17-bit signed, in 1/64 px. `BOTTOM` = 479*64 = 30656. `TOPPOS` = `TOP_LIMIT`*64.
- `topY` = pos >> 6. Pos is always within [TOPPOS, BOTTOM], so the output is never negative.
- Deploy latch per rope:
  - Set by `deploy[i]` in IDLE.
  - Cleared on the `startOfFrame` that consumes it.
  - Cleared by `hit[i]`.
  - Deploy in RISE or HOLD is ignored and not latched.
- States per rope: IDLE, RISE, HOLD.
- IDLE:
  - pos = BOTTOM.
  - On `startOfFrame` with the latch set (or `deploy[i]` high that cycle): go to RISE. pos is unchanged on that frame.
- RISE, on each `startOfFrame`:
  - If pos - `Y_SPEED` > TOPPOS: pos -= `Y_SPEED`.
  - Otherwise: pos = TOPPOS. With `ROPE_HOLD_EN`, go to HOLD and load the hold counter with `HOLD_FRAMES`. Without it, go to IDLE with pos = BOTTOM and pulse `retracted`.
- HOLD:
  - The counter decrements on each `startOfFrame`.
  - When the counter is 0 at a `startOfFrame`: go to IDLE, pos = BOTTOM, pulse `retracted`.
  - `HOLD_FRAMES` = 0 gives exactly one frame at the top.
- Hit:
  - `hit[i]` in RISE or HOLD: go to IDLE, pos = BOTTOM, pulse `retracted`.
  - Hit has priority over `startOfFrame` and deploy in the same cycle.
  - Hit in IDLE has no effect, except that it clears the latch.
- Channels are fully independent. Simultaneous events on different ropes are all serviced in the same cycle.

## Timing
- Reset values:
  - `topY` = 479 for every rope.
  - `movingUp` = 0 and `retracted` = 0.
  - All ropes in IDLE; latches and counters cleared.
- Reset mid-flight returns the rope to BOTTOM on the next edge. No `retracted` pulse is produced by reset.
- All outputs are registered or decoded from registered state. Each change is visible the cycle after the causing edge.
- `movingUp[i]` rises 1 cycle after the deploying `startOfFrame`. It falls 1 cycle after the clamp (non-hold), the hold expiry, or the hit.
- `retracted[i]` is high for exactly 1 cycle, aligned with `movingUp[i]` falling.
- No pos change occurs between `startOfFrame` pulses.

## Configuration
- Macro `ROPE_HOLD_EN`.
- Defined: the HOLD state and hold counter are built. The rope sticks at `TOP_LIMIT` for `HOLD_FRAMES`+1 frames.
- Undefined: no HOLD state and no counter logic. A rope reaching the top retracts on that same frame update, and `HOLD_FRAMES` is ignored.

## Test plan
- Reset, then idle with no stimulus: every `topY` = 479, `movingUp` = 0, and `retracted` never pulses.
- Deploy on rope 0, then run frames:
  - Deploy frame: `movingUp[0]` = 1, `topY` = 479.
  - After 1 rise frame: pos = 30506, `topY` = 476.
  - After 193 frames: pos = 1706, `topY` = 26.
  - Frame 194: pos clamps to 1664, `topY` = 26.
  - With `ROPE_HOLD_EN`: 31 further frames at 26, then `retracted` pulses and `topY` = 479.
- Build without `ROPE_HOLD_EN`, same stimulus: at frame 194 `topY` returns to 479 and `retracted[0]` pulses once.
- Rope 1 at frame 50 (pos = 23156), `hit[1]` asserted in the same cycle as `startOfFrame`: next cycle `topY` = 479 and `movingUp[1]` = 0. Rope 0 is unaffected.
- Deploy rope 0 during RISE, and deploy plus hit asserted together in IDLE: neither causes a launch on the next `startOfFrame`.
- Assert `resetN` at rope 0 frame 100: next cycle `topY` = 479, `movingUp` = 0, and no `retracted` pulse.
